// File: rtl/mult_pipe_elastic.sv
`default_nettype none
// ============================================================================
// Module   : mult_pipe_elastic
// Brief    : Elastic radix-2^SHIFT pipelined multiplier with CDB request/grant handshake.
// Revision : 1.0 - initial release
// ============================================================================
module mult_pipe_elastic #(
  parameter int XLEN   = 32,
  parameter int STAGES = 4,
  parameter int META_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic              ready,
  input  logic [XLEN-1:0]   rs1,
  input  logic [XLEN-1:0]   rs2,
  input  logic [1:0]        func,
  input  logic [META_W-1:0] meta_in,
  input  logic              flush,
  input  logic              grant,
  output logic              request,
  output logic [META_W-1:0] req_meta,
  output logic              done,
  output logic [XLEN-1:0]   result,
  output logic [META_W-1:0] meta_out,
  output logic              busy
);

  localparam int c_W     = 2 * XLEN;
  localparam int c_SHIFT = c_W / STAGES;

  // func encoding shared with the issue logic
  localparam logic [1:0] c_FUNC_MUL    = 2'd0;
  localparam logic [1:0] c_FUNC_MULH   = 2'd1;
  localparam logic [1:0] c_FUNC_MULHSU = 2'd2;
  localparam logic [1:0] c_FUNC_MULHU  = 2'd3;

  logic [STAGES-1:0] r_valid;
  logic [c_W-1:0]    r_sum    [STAGES];
  logic [c_W-1:0]    r_mcand  [STAGES-1];
  logic [c_W-1:0]    r_mplier [STAGES-1];
  logic [1:0]        r_func   [STAGES];
  logic [META_W-1:0] r_meta   [STAGES];

  logic [STAGES-2:0] w_adv;
  logic [STAGES-1:0] w_valid_nx;
  logic [STAGES-1:0] w_load;
  logic              w_accept;
  logic              w_mcand_sx;
  logic              w_mplier_sx;
  logic [c_W-1:0]    w_mcand_ext;
  logic [c_W-1:0]    w_mplier_ext;
  logic [c_W-1:0]    w_sum_src    [STAGES];
  logic [c_W-1:0]    w_mcand_src  [STAGES];
  logic [c_W-1:0]    w_mplier_src [STAGES];
  logic [c_W-1:0]    w_partial    [STAGES];
  logic [1:0]        w_func_src   [STAGES];
  logic [META_W-1:0] w_meta_src   [STAGES];

  assign w_mcand_sx   = (func == c_FUNC_MUL) || (func == c_FUNC_MULH) || (func == c_FUNC_MULHSU);
  assign w_mplier_sx  = (func != c_FUNC_MULHSU) && (func != c_FUNC_MULHU);
  assign w_mcand_ext  = {{XLEN{w_mcand_sx & rs1[XLEN-1]}}, rs1};
  assign w_mplier_ext = {{XLEN{w_mplier_sx & rs2[XLEN-1]}}, rs2};

  // Advance chain resolved from the tail; only the request stage waits on grant.
  always_comb begin
    w_adv = '0;
    w_adv[STAGES-2] = r_valid[STAGES-2] & grant;
    for (int k = STAGES - 3; k >= 0; k--) begin
      w_adv[k] = r_valid[k] & (~r_valid[k+1] | w_adv[k+1]);
    end
  end

  assign ready    = ~r_valid[0] | w_adv[0];
  assign w_accept = start & ready & ~flush;

  always_comb begin
    w_valid_nx    = '0;
    w_valid_nx[0] = w_accept | (r_valid[0] & ~w_adv[0]);
    for (int k = 1; k < STAGES - 1; k++) begin
      w_valid_nx[k] = w_adv[k-1] | (r_valid[k] & ~w_adv[k]);
    end
    w_valid_nx[STAGES-1] = w_adv[STAGES-2];
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      r_valid <= '0;
    end else begin
      r_valid <= w_valid_nx;
    end
  end

  generate
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
      if (k == 0) begin : g_head
        assign w_load[k]       = w_accept;
        assign w_sum_src[k]    = '0;
        assign w_mcand_src[k]  = w_mcand_ext;
        assign w_mplier_src[k] = w_mplier_ext;
        assign w_func_src[k]   = func;
        assign w_meta_src[k]   = meta_in;
      end else begin : g_body
        assign w_load[k]       = w_adv[k-1];
        assign w_sum_src[k]    = r_sum[k-1];
        assign w_mcand_src[k]  = r_mcand[k-1];
        assign w_mplier_src[k] = r_mplier[k-1];
        assign w_func_src[k]   = r_func[k-1];
        assign w_meta_src[k]   = r_meta[k-1];
      end
      assign w_partial[k] = {{(c_W-c_SHIFT){1'b0}}, w_mplier_src[k][c_SHIFT-1:0]} * w_mcand_src[k];
    end
  endgenerate

  // The final stage only accumulates, so it carries no operand registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) begin
        r_sum[k]  <= '0;
        r_func[k] <= '0;
        r_meta[k] <= '0;
      end
      for (int k = 0; k < STAGES - 1; k++) begin
        r_mcand[k]  <= '0;
        r_mplier[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (w_load[k]) begin
          r_sum[k]  <= w_sum_src[k] + w_partial[k];
          r_func[k] <= w_func_src[k];
          r_meta[k] <= w_meta_src[k];
        end
      end
      for (int k = 0; k < STAGES - 1; k++) begin
        if (w_load[k]) begin
          r_mcand[k]  <= w_mcand_src[k] << c_SHIFT;
          r_mplier[k] <= w_mplier_src[k] >> c_SHIFT;
        end
      end
    end
  end

  assign request  = r_valid[STAGES-2];
  assign req_meta = r_meta[STAGES-2];
  assign done     = r_valid[STAGES-1];
  assign meta_out = r_meta[STAGES-1];
  assign result   = (r_func[STAGES-1] == c_FUNC_MUL) ? r_sum[STAGES-1][XLEN-1:0]
                                                     : r_sum[STAGES-1][c_W-1:XLEN];
  assign busy     = |r_valid;

endmodule
`default_nettype wire
